// File: rtl/falafel_fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write arbiter.
package falafel_fifo_arb_pkg;

  // ARB: free round-robin arbitration; LOCKED: a multi-beat packet owns the port.
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Widest requester vector the pick helper handles (NUM_REQ must not exceed it).
  localparam int unsigned MAX_REQ       = 32;
  localparam int unsigned MAX_REQ_IDX_W = 5;

  // One-hot grant of the first eligible bit at or above ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] eligible,
    input int unsigned        ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int unsigned        idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && idx < MAX_REQ && eligible[idx[MAX_REQ_IDX_W-1:0]]) begin
        grant[idx[MAX_REQ_IDX_W-1:0]] = 1'b1;
        found                         = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/falafel_rr_picker.sv
// Combinational round-robin picker: one-hot grant plus its binary index.
module falafel_rr_picker
  import falafel_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o
);

  logic [MAX_REQ-1:0] elig_wide;
  logic [MAX_REQ-1:0] grant_wide;

  // Widen the request vector to the helper's fixed width and scan from the pointer.
  always_comb begin
    elig_wide              = '0;
    elig_wide[NUM_REQ-1:0] = eligible_i;
    grant_wide             = rr_pick(elig_wide, 32'(ptr_i), unsigned'(NUM_REQ));
  end

  assign grant_o = grant_wide[NUM_REQ-1:0];

  generate
    if (NUM_REQ < MAX_REQ) begin : g_pad
      logic unused_hi;
      assign unused_hi = |grant_wide[MAX_REQ-1:NUM_REQ];
    end
  endgenerate

  // Encode the one-hot grant; index is 0 when nothing is granted.
  always_comb begin
    grant_idx_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_o[r]) grant_idx_o = ID_W'(r);
    end
  end

endmodule

// File: rtl/falafel_fifo_write_arbiter.sv
// Round-robin, credit-limited sharing of one FIFO write port among NUM_REQ
// requesters; multi-beat packets hold the grant until their last beat.
module falafel_fifo_write_arbiter
  import falafel_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_W   = 16,
  parameter  int MAX_CRED = 8,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int CRED_W   = $clog2(MAX_CRED + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      fifo_full_i,
  output logic                      fifo_write_o,
  output logic [ID_W+DATA_W-1:0]    fifo_din_o,
  input  logic                      fifo_empty_i,
  input  logic                      fifo_read_i,
  input  logic [ID_W+DATA_W-1:0]    fifo_dout_i,
  output logic [NUM_REQ*CRED_W-1:0] credit_o,
  output logic                      locked_o
);

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_CRED);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CRED_W-1:0] credit_q [NUM_REQ];
  logic [CRED_W-1:0] credit_d [NUM_REQ];

  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] has_credit;
  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] cred_inc;
  logic [NUM_REQ-1:0] cred_ovf;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    head_id;
  logic [DATA_W-1:0]  grant_data;
  logic               accept;
  logic               grant_last;
  logic               pop_valid;
  logic               unused_dout;

  // Only the id field of the FIFO head matters for credit return.
  assign head_id     = fifo_dout_i[ID_W+DATA_W-1 -: ID_W];
  assign unused_dout = ^fifo_dout_i[DATA_W-1:0];
  assign pop_valid   = fifo_read_i && !fifo_empty_i;

  // Per-requester slicing, eligibility terms and credit returns. Head ids at or
  // above NUM_REQ match no requester and so return no credit.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]                  = req_data_i[gi*DATA_W +: DATA_W];
      assign has_credit[gi]                = (credit_q[gi] != '0);
      assign owner_mask[gi]                = (state_q == ARB) || (owner_q == ID_W'(gi));
      assign cred_inc[gi]                  = pop_valid && (head_id == ID_W'(gi));
      assign credit_o[gi*CRED_W +: CRED_W] = credit_q[gi];
    end
  endgenerate

  // Reset gating keeps every output quiet while rst_i is high, even with valids up.
  assign eligible = req_valid_i & has_credit & owner_mask &
                    {NUM_REQ{!fifo_full_i && !rst_i}};

  falafel_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .eligible_i  (eligible),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign accept     = |grant;
  assign grant_last = |(grant & req_last_i);

  // Select the granted beat (grant is one-hot) and drive the write port.
  always_comb begin
    grant_data = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant[r]) grant_data = grant_data | data_arr[r];
    end
    req_ready_o  = grant;
    fifo_write_o = accept;
    fifo_din_o   = accept ? {grant_idx, grant_data} : '0;
  end

  assign locked_o = (state_q == LOCKED);

  // Packet lock FSM and round-robin pointer, which advances only when a packet ends.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB: begin
        if (accept && !grant_last) begin
          state_d = LOCKED;
          owner_d = grant_idx;
        end
      end
      LOCKED: begin
        if (accept && grant_last) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (accept && grant_last) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Credit next-state: push consumes one, pop of a matching head returns one.
  always_comb begin
    cred_ovf = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      credit_d[r] = credit_q[r];
      if (grant[r] && !cred_inc[r]) begin
        credit_d[r] = credit_q[r] - 1'b1;
      end else if (cred_inc[r] && !grant[r]) begin
        if (credit_q[r] == CRED_MAX) cred_ovf[r] = 1'b1;
        else                         credit_d[r] = credit_q[r] + 1'b1;
      end
    end
  end

  // State, owner, pointer and credit registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      owner_q <= '0;
      ptr_q   <= '0;
      for (int r = 0; r < NUM_REQ; r++) credit_q[r] <= CRED_MAX;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  // A credit return at MAX_CRED means the consumer popped something never pushed.
  assert property (@(posedge clk_i) disable iff (rst_i) cred_ovf == '0);

endmodule

// File: tb/tb_falafel_fifo_write_arbiter.sv
// Directed bench for falafel_fifo_write_arbiter with a queue-based FIFO and an
// arbitration model checked every cycle, plus hand-computed expectations.
module tb_falafel_fifo_write_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_valid_i;
  logic [3:0]  req_last_i;
  logic [63:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        fifo_full_i;
  logic        fifo_write_o;
  logic [17:0] fifo_din_o;
  logic        fifo_empty_i;
  logic        fifo_read_i;
  logic [17:0] fifo_dout_i;
  logic [15:0] credit_o;
  logic        locked_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  int cyc      = 0;

  // Model: credits, lock owner, rr pointer and the FIFO contents (ids only).
  int         m_cred [4];
  bit         m_locked;
  int         m_owner;
  int         m_ptr;
  logic [1:0] q_ids [$];

  falafel_fifo_write_arbiter #(
    .NUM_REQ  (4),
    .DATA_W   (16),
    .MAX_CRED (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_last_i   (req_last_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_write_o (fifo_write_o),
    .fifo_din_o   (fifo_din_o),
    .fifo_empty_i (fifo_empty_i),
    .fifo_read_i  (fifo_read_i),
    .fifo_dout_i  (fifo_dout_i),
    .credit_o     (credit_o),
    .locked_o     (locked_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Which requester must win this cycle (-1 = none), from the arbitration rules.
  function automatic int model_grant();
    int r;
    if (rst_i || fifo_full_i) return -1;
    if (m_locked) begin
      if (req_valid_i[m_owner[1:0]] && m_cred[m_owner[1:0]] > 0) return m_owner;
      return -1;
    end
    for (int k = 0; k < 4; k++) begin
      r = (m_ptr + k) % 4;
      if (req_valid_i[r[1:0]] && m_cred[r[1:0]] > 0) return r;
    end
    return -1;
  endfunction

  // Model state update on each clock, with asynchronous reset.
  always @(posedge clk_i or posedge rst_i) begin
    int g;
    int inc_id;
    if (rst_i) begin
      for (int r = 0; r < 4; r++) m_cred[r] <= 8;
      m_locked <= 1'b0;
      m_owner  <= 0;
      m_ptr    <= 0;
      q_ids.delete();
    end else begin
      g      = model_grant();
      inc_id = -1;
      if (fifo_read_i && !fifo_empty_i) begin
        inc_id = int'(fifo_dout_i[17:16]);
        if (q_ids.size() != 0) void'(q_ids.pop_front());
      end
      for (int r = 0; r < 4; r++) begin
        if (g == r && inc_id != r)                     m_cred[r] <= m_cred[r] - 1;
        else if (inc_id == r && g != r && m_cred[r] < 8) m_cred[r] <= m_cred[r] + 1;
      end
      if (g >= 0) begin
        q_ids.push_back(g[1:0]);
        if (!m_locked && !req_last_i[g[1:0]]) begin
          m_locked <= 1'b1;
          m_owner  <= g;
        end else if (req_last_i[g[1:0]]) begin
          m_locked <= 1'b0;
          m_ptr    <= (g + 1) % 4;
        end
      end
    end
  end

  // Compare all DUT outputs against the model mid-cycle.
  always @(negedge clk_i) begin
    int          g;
    logic [3:0]  exp_ready;
    logic [17:0] exp_din;
    logic [15:0] exp_cred;
    #2;
    if (cmp_en) begin
      g         = model_grant();
      exp_ready = '0;
      exp_din   = '0;
      if (g >= 0) begin
        exp_ready[g[1:0]] = 1'b1;
        exp_din           = {g[1:0], req_data_i[g*16 +: 16]};
      end
      for (int r = 0; r < 4; r++) exp_cred[r*4 +: 4] = m_cred[r][3:0];
      check("model_ready",  32'(req_ready_o),  32'(exp_ready));
      check("model_write",  32'(fifo_write_o), 32'(g >= 0));
      check("model_din",    32'(fifo_din_o),   32'(exp_din));
      check("model_credit", 32'(credit_o),     32'(exp_cred));
      check("model_locked", 32'(locked_o),     32'(m_locked));
      if (g >= 0) $display("beat t=%0t id=%0d data=%h credits=%h", $time, g, fifo_din_o[15:0], credit_o);
    end
  end

  // One cycle of stimulus; the FIFO head/empty come from the model queue.
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic rd,
                       input logic full, input logic force_empty);
    @(negedge clk_i);
    cyc++;
    req_valid_i  = v;
    req_last_i   = l;
    fifo_read_i  = rd;
    fifo_full_i  = full;
    fifo_empty_i = force_empty || (q_ids.size() == 0);
    fifo_dout_i  = (q_ids.size() != 0) ? {q_ids[0], 16'h0000} : 18'h0;
    for (int r = 0; r < 4; r++) req_data_i[r*16 +: 16] = 16'((r << 12) | (cyc & 12'hfff));
    #3;
  endtask

  task automatic drain();
    while (q_ids.size() != 0) drive(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] lock_ready [4];
    logic       lock_locked [4];
    lock_ready  = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
    lock_locked = '{1'b0, 1'b1, 1'b1, 1'b0};

    rst_i        = 1'b1;
    req_valid_i  = 4'hF;
    req_last_i   = 4'hF;
    req_data_i   = '0;
    fifo_full_i  = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_read_i  = 1'b0;
    fifo_dout_i  = '0;

    // Reset holds outputs quiet even with every requester valid.
    @(negedge clk_i);
    #3;
    check("rst_ready",  32'(req_ready_o),  32'h0);
    check("rst_write",  32'(fifo_write_o), 32'h0);
    check("rst_din",    32'(fifo_din_o),   32'h0);
    check("rst_credit", 32'(credit_o),     32'h8888);
    check("rst_locked", 32'(locked_o),     32'h0);
    @(negedge clk_i);
    rst_i       = 1'b0;
    req_valid_i = 4'h0;
    cmp_en      = 1'b1;

    // Round-robin over all four single-beat requesters.
    for (int i = 0; i < 8; i++) begin
      drive(4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
      check("rr_ready", 32'(req_ready_o), 32'(1) << (i % 4));
      check("rr_id",    32'(fifo_din_o[17:16]), 32'(i % 4));
    end
    drain();

    // Move the pointer to 1, then requester 1 sends a 3-beat packet.
    drive(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    check("pre_lock_ready", 32'(req_ready_o), 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (i < 2)       drive(4'b0111, 4'b0101, 1'b0, 1'b0, 1'b0);
      else if (i == 2) drive(4'b0111, 4'b0111, 1'b0, 1'b0, 1'b0);
      else             drive(4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0);
      check("lock_ready",  32'(req_ready_o), 32'(lock_ready[i]));
      check("lock_locked", 32'(locked_o),    32'(lock_locked[i]));
    end
    drain();

    // Requester 0 alone exhausts its credits, then one pop frees one slot.
    for (int i = 0; i < 8; i++) begin
      drive(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
      check("exh_ready", 32'(req_ready_o), 32'h1);
    end
    drive(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    check("exh_stall_ready",  32'(req_ready_o), 32'h0);
    check("exh_stall_credit", 32'(credit_o),    32'h8880);
    drive(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    check("exh_pop_ready", 32'(req_ready_o), 32'h0);
    drive(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    check("exh_ret_credit", 32'(credit_o),    32'h8881);
    check("exh_ret_ready",  32'(req_ready_o), 32'h1);
    drain();

    // Requester 2 to credit 5, then simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
      check("r2_ready", 32'(req_ready_o), 32'h4);
    end
    drive(4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);
    check("pp_ready",  32'(req_ready_o), 32'h4);
    check("pp_credit", 32'(credit_o),    32'h8588);
    // FIFO full: nothing written, credits hold.
    for (int i = 0; i < 2; i++) begin
      drive(4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
      check("full_write",  32'(fifo_write_o), 32'h0);
      check("full_ready",  32'(req_ready_o),  32'h0);
      check("full_credit", 32'(credit_o),     32'h8588);
    end
    // Pop while the FIFO reports empty is ignored.
    drive(4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("empty_pop_credit", 32'(credit_o), 32'h8588);
    drain();

    // Requester 3 locks, then stalls for 4 cycles while others are valid.
    drive(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("stall_first_ready", 32'(req_ready_o), 32'h8);
    for (int i = 0; i < 4; i++) begin
      drive(4'b0111, 4'b1111, 1'b0, 1'b0, 1'b0);
      check("stall_ready",  32'(req_ready_o), 32'h0);
      check("stall_locked", 32'(locked_o),    32'h1);
    end
    drive(4'b1111, 4'b1000, 1'b0, 1'b0, 1'b0);
    check("stall_last_ready", 32'(req_ready_o), 32'h8);
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("stall_unlocked", 32'(locked_o), 32'h0);
    drain();

    // Reset in the middle of a packet.
    drive(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("mid_first_ready", 32'(req_ready_o), 32'h1);
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("mid_locked", 32'(locked_o), 32'h1);
    req_valid_i = 4'hF;
    rst_i       = 1'b1;
    #1;
    check("mid_rst_locked", 32'(locked_o),     32'h0);
    check("mid_rst_ready",  32'(req_ready_o),  32'h0);
    check("mid_rst_write",  32'(fifo_write_o), 32'h0);
    check("mid_rst_credit", 32'(credit_o),     32'h8888);
    @(negedge clk_i);
    rst_i       = 1'b0;
    req_valid_i = 4'h0;
    drive(4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0);
    check("post_rst_ready", 32'(req_ready_o), 32'h2);
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
